// File: rtl/frame_capture_writer_if.sv
// BRAM write port between the frame capture writer (master) and the frame buffer (slave).
interface frame_capture_writer_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/frame_capture_writer.sv
// Camera pixel stream to BRAM write port: decimation, single/double buffering,
// snapshot and frame-skip capture modes, and sticky frame-integrity flags.
module frame_capture_writer #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int DATA_W    = 12,
    parameter int ADDR_W    = 19,
    parameter int DS_SHIFT  = 0,
    parameter int NUM_BANKS = 1
) (
    input  logic                   sysclk,
    input  logic                   sysrst,
    input  logic                   config_done,
    input  logic                   frame_start,
    input  logic                   frame_done,
    input  logic                   pixel_valid,
    input  logic [DATA_W-1:0]      pixel_data,
    input  logic [1:0]             mode,
    input  logic                   snap_req,
    input  logic [3:0]             skip_n,
    frame_capture_writer_if.master wr,
    output logic                   read_bank,
    output logic                   frame_ready,
    output logic                   busy,
    output logic [15:0]            frame_count,
    output logic                   overflow,
    output logic                   short_frame
);
    localparam int X_W     = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W     = $clog2(V_RES + 1);
    localparam int ROW_W   = H_RES >> DS_SHIFT;
    localparam int BANK_SZ = ROW_W * (V_RES >> DS_SHIFT);
    localparam int DS_MASK = (1 << DS_SHIFT) - 1;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLD} state_t;

    state_t            state;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] row_base;
    logic              wr_bank;
    logic [3:0]        skip_cnt;
    logic              snap_armed;

    logic              stop;
    logic              boundary;
    logic              take;
    logic              x_last;
    logic              in_frame;
    logic              keep;
    logic              next_row_kept;
    logic              full_after;
    logic [ADDR_W-1:0] bank_base;
    logic [ADDR_W-1:0] pix_addr;

    // NOTE: every signal of this block is assigned on every path, so no latch is inferred.
    always_comb begin
        stop          = (mode == 2'd3);
        boundary      = frame_start || frame_done;
        take          = (mode == 2'd0) ||
                        (mode == 2'd1 && snap_armed) ||
                        (mode == 2'd2 && skip_cnt == 4'd0);
        x_last        = (int'(x) == H_RES - 1);
        in_frame      = (int'(y) < V_RES);
        keep          = ((int'(x) & DS_MASK) == 0) && ((int'(y) & DS_MASK) == 0);
        next_row_kept = (((int'(y) + 1) & DS_MASK) == 0);
        // Frame holds all H_RES*V_RES pixels once this cycle's pixel is counted.
        full_after    = !in_frame || (pixel_valid && x_last && int'(y) == V_RES - 1);
        bank_base     = (NUM_BANKS == 2 && wr_bank) ? ADDR_W'(BANK_SZ) : '0;
        pix_addr      = bank_base + row_base + ADDR_W'(int'(x) >> DS_SHIFT);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            row_base    <= '0;
            wr_bank     <= 1'b0;
            skip_cnt    <= 4'd0;
            snap_armed  <= 1'b0;
            wr.wr_en    <= 1'b0;
            wr.wr_addr  <= '0;
            wr.wr_data  <= '0;
            read_bank   <= 1'b0;
            frame_ready <= 1'b0;
            busy        <= 1'b0;
            frame_count <= 16'd0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            wr.wr_en    <= 1'b0;
            frame_ready <= 1'b0;

            case (state)
                IDLE: begin
                    if (config_done && !stop) state <= ARMED;
                end

                ARMED: begin
                    if (stop && boundary) begin
                        state <= IDLE;
                    end else if (frame_start) begin
                        if (take) begin
                            state      <= CAPTURE;
                            busy       <= 1'b1;
                            x          <= '0;
                            y          <= '0;
                            row_base   <= '0;
                            snap_armed <= 1'b0;
                        end else if (mode == 2'd2) begin
                            skip_cnt <= skip_cnt - 4'd1;
                        end
                    end
                end

                CAPTURE: begin
                    if (frame_start) begin
                        // Abort: restart in the same bank, the lost frame counts as short.
                        short_frame <= 1'b1;
                        x           <= '0;
                        y           <= '0;
                        row_base    <= '0;
                        if (stop) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        if (pixel_valid) begin
                            if (in_frame) begin
                                if (keep) begin
                                    wr.wr_en   <= 1'b1;
                                    wr.wr_addr <= pix_addr;
                                    wr.wr_data <= pixel_data;
                                end
                                if (x_last) begin
                                    x <= '0;
                                    y <= y + Y_W'(1);
                                    if (next_row_kept) row_base <= row_base + ADDR_W'(ROW_W);
                                end else begin
                                    x <= x + X_W'(1);
                                end
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                        if (frame_done) begin
                            frame_count <= frame_count + 16'd1;
                            frame_ready <= 1'b1;
                            busy        <= 1'b0;
                            if (!full_after) short_frame <= 1'b1;
                            if (NUM_BANKS == 2) begin
                                read_bank <= wr_bank;
                                wr_bank   <= ~wr_bank;
                            end
                            if (mode == 2'd2) skip_cnt <= skip_n;
                            if (stop)                state <= IDLE;
                            else if (mode == 2'd1)   state <= HOLD;
                            else                     state <= ARMED;
                        end
                    end
                end

                HOLD: begin
                    if (stop && boundary)           state <= IDLE;
                    else if (snap_req || snap_armed) state <= ARMED;
                end

                default: state <= IDLE;
            endcase

            // A request in the same cycle as a capture start stays armed for the next frame.
            if (snap_req) snap_armed <= 1'b1;
        end
    end
endmodule

// File: tb/tb_frame_capture_writer.sv
// Bench for frame_capture_writer: three configurations share one stimulus stream and
// are compared every cycle against a frame-level reference model.
module tb_frame_capture_writer;
    localparam int H = 8;
    localparam int V = 4;
    localparam int NVEC = 16;

    logic        sysclk;
    logic        sysrst;
    logic        config_done;
    logic        frame_start;
    logic        frame_done;
    logic        pixel_valid;
    logic [11:0] pixel_data;
    logic [1:0]  mode;
    logic        snap_req;
    logic [3:0]  skip_n;

    logic        rb0, rdy0, busy0, ovf0, sht0;
    logic        rb1, rdy1, busy1, ovf1, sht1;
    logic        rb2, rdy2, busy2, ovf2, sht2;
    logic [15:0] fc0, fc1, fc2;

    frame_capture_writer_if #(.ADDR_W(6), .DATA_W(12)) bus0 ();
    frame_capture_writer_if #(.ADDR_W(6), .DATA_W(12)) bus1 ();
    frame_capture_writer_if #(.ADDR_W(6), .DATA_W(12)) bus2 ();

    frame_capture_writer #(.H_RES(H), .V_RES(V), .DATA_W(12), .ADDR_W(6), .DS_SHIFT(0), .NUM_BANKS(1)) dut0 (
        .sysclk(sysclk), .sysrst(sysrst), .config_done(config_done), .frame_start(frame_start),
        .frame_done(frame_done), .pixel_valid(pixel_valid), .pixel_data(pixel_data), .mode(mode),
        .snap_req(snap_req), .skip_n(skip_n), .wr(bus0), .read_bank(rb0), .frame_ready(rdy0),
        .busy(busy0), .frame_count(fc0), .overflow(ovf0), .short_frame(sht0));

    frame_capture_writer #(.H_RES(H), .V_RES(V), .DATA_W(12), .ADDR_W(6), .DS_SHIFT(0), .NUM_BANKS(2)) dut1 (
        .sysclk(sysclk), .sysrst(sysrst), .config_done(config_done), .frame_start(frame_start),
        .frame_done(frame_done), .pixel_valid(pixel_valid), .pixel_data(pixel_data), .mode(mode),
        .snap_req(snap_req), .skip_n(skip_n), .wr(bus1), .read_bank(rb1), .frame_ready(rdy1),
        .busy(busy1), .frame_count(fc1), .overflow(ovf1), .short_frame(sht1));

    frame_capture_writer #(.H_RES(H), .V_RES(V), .DATA_W(12), .ADDR_W(6), .DS_SHIFT(1), .NUM_BANKS(2)) dut2 (
        .sysclk(sysclk), .sysrst(sysrst), .config_done(config_done), .frame_start(frame_start),
        .frame_done(frame_done), .pixel_valid(pixel_valid), .pixel_data(pixel_data), .mode(mode),
        .snap_req(snap_req), .skip_n(skip_n), .wr(bus2), .read_bank(rb2), .frame_ready(rdy2),
        .busy(busy2), .frame_count(fc2), .overflow(ovf2), .short_frame(sht2));

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_checks;
    int n_errors;
    int w_cnt [3];
    int rdy_cnt;

    // Reference model: frame phase plus pixel index within the frame.
    typedef enum {M_IDLE, M_ARMED, M_CAP, M_HOLD} mphase_t;
    mphase_t     m_ph;
    int          m_npix;
    bit          m_snap;
    int          m_skip;
    logic [15:0] m_fc;
    bit          m_ovf, m_short, m_ready;
    bit          m_wb [3];
    bit          m_rb [3];
    bit          e_wen [3];
    int          e_addr [3];
    int          e_data [3];

    typedef struct {
        logic [1:0] mode;
        logic [3:0] skip;
        bit         snap;
        int         npix;
        bit         abort;
        int         exp_w0;
        int         exp_w1;
        int         exp_w2;
        int         exp_ready;
    } vec_t;
    vec_t vecs [NVEC];

    task automatic check(string name, int idx, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = M_IDLE; m_npix = 0; m_snap = 1'b0; m_skip = 0; m_fc = '0;
        m_ovf = 1'b0; m_short = 1'b0; m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            m_wb[c] = 1'b0; m_rb[c] = 1'b0; e_wen[c] = 1'b0; e_addr[c] = 0; e_data[c] = 0;
        end
    endtask

    task automatic model_step();
        int x, y, s, cols;
        bit stop, bound, take;
        for (int c = 0; c < 3; c++) e_wen[c] = 1'b0;
        m_ready = 1'b0;
        if (sysrst) begin
            model_reset();
            return;
        end
        stop  = (mode == 2'd3);
        bound = frame_start || frame_done;
        case (m_ph)
            M_IDLE: if (config_done && !stop) m_ph = M_ARMED;
            M_ARMED: begin
                if (stop && bound) m_ph = M_IDLE;
                else if (frame_start) begin
                    take = (mode == 2'd0) || (mode == 2'd1 && m_snap) || (mode == 2'd2 && m_skip == 0);
                    if (take) begin
                        m_ph = M_CAP; m_npix = 0; m_snap = 1'b0;
                    end else if (mode == 2'd2) begin
                        m_skip = m_skip - 1;
                    end
                end
            end
            M_CAP: begin
                if (frame_start) begin
                    m_short = 1'b1; m_npix = 0;
                    if (stop) m_ph = M_IDLE;
                end else begin
                    if (pixel_valid) begin
                        if (m_npix < H * V) begin
                            x = m_npix % H;
                            y = m_npix / H;
                            for (int c = 0; c < 3; c++) begin
                                s = (c == 2) ? 2 : 1;
                                cols = H / s;
                                if (x % s == 0 && y % s == 0) begin
                                    e_wen[c]  = 1'b1;
                                    e_addr[c] = (m_wb[c] ? cols * (V / s) : 0) + (y / s) * cols + x / s;
                                    e_data[c] = int'(pixel_data);
                                end
                            end
                            m_npix++;
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                    if (frame_done) begin
                        m_fc++;
                        m_ready = 1'b1;
                        if (m_npix < H * V) m_short = 1'b1;
                        for (int c = 1; c < 3; c++) begin
                            m_rb[c] = m_wb[c];
                            m_wb[c] = !m_wb[c];
                        end
                        if (mode == 2'd2) m_skip = int'(skip_n);
                        m_ph = stop ? M_IDLE : ((mode == 2'd1) ? M_HOLD : M_ARMED);
                    end
                end
            end
            M_HOLD: begin
                if (stop && bound) m_ph = M_IDLE;
                else if (snap_req || m_snap) m_ph = M_ARMED;
            end
            default: m_ph = M_IDLE;
        endcase
        if (snap_req) m_snap = 1'b1;
    endtask

    task automatic check_dut(int c, logic wen, logic [5:0] addr, logic [11:0] data, logic rb,
                             logic rdy, logic bsy, logic [15:0] fc, logic ovf, logic sht);
        check("wr_en", c, int'(wen), int'(e_wen[c]));
        if (e_wen[c]) begin
            check("wr_addr", c, int'(addr), e_addr[c]);
            check("wr_data", c, int'(data), e_data[c]);
        end
        check("read_bank", c, int'(rb), int'(m_rb[c]));
        check("frame_ready", c, int'(rdy), int'(m_ready));
        check("busy", c, int'(bsy), int'(m_ph == M_CAP));
        check("frame_count", c, int'(fc), int'(m_fc));
        check("overflow", c, int'(ovf), int'(m_ovf));
        check("short_frame", c, int'(sht), int'(m_short));
        if (wen) w_cnt[c]++;
    endtask

    task automatic tick();
        @(posedge sysclk);
        model_step();
        #1;
        check_dut(0, bus0.wr_en, bus0.wr_addr, bus0.wr_data, rb0, rdy0, busy0, fc0, ovf0, sht0);
        check_dut(1, bus1.wr_en, bus1.wr_addr, bus1.wr_data, rb1, rdy1, busy1, fc1, ovf1, sht1);
        check_dut(2, bus2.wr_en, bus2.wr_addr, bus2.wr_data, rb2, rdy2, busy2, fc2, ovf2, sht2);
        if (rdy0) rdy_cnt++;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        pixel_valid = 1'b0;
        snap_req    = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic zero_check(int c, logic wen, logic [5:0] addr, logic [11:0] data, logic rb,
                              logic rdy, logic bsy, logic [15:0] fc, logic ovf, logic sht);
        check("rst wr_en", c, int'(wen), 0);
        check("rst wr_addr", c, int'(addr), 0);
        check("rst wr_data", c, int'(data), 0);
        check("rst read_bank", c, int'(rb), 0);
        check("rst frame_ready", c, int'(rdy), 0);
        check("rst busy", c, int'(bsy), 0);
        check("rst frame_count", c, int'(fc), 0);
        check("rst overflow", c, int'(ovf), 0);
        check("rst short_frame", c, int'(sht), 0);
    endtask

    task automatic reset_checks();
        zero_check(0, bus0.wr_en, bus0.wr_addr, bus0.wr_data, rb0, rdy0, busy0, fc0, ovf0, sht0);
        zero_check(1, bus1.wr_en, bus1.wr_addr, bus1.wr_data, rb1, rdy1, busy1, fc1, ovf1, sht1);
        zero_check(2, bus2.wr_en, bus2.wr_addr, bus2.wr_data, rb2, rdy2, busy2, fc2, ovf2, sht2);
    endtask

    task automatic run_vec(vec_t v, int base);
        mode   = v.mode;
        skip_n = v.skip;
        if (v.snap) begin
            snap_req = 1'b1;
            tick();
        end
        idle(2);
        frame_start = 1'b1;
        tick();
        idle(1);
        for (int i = 0; i < v.npix; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = 12'(base + i);
            tick();
            if (i % 3 == 2) idle(1);
        end
        if (v.abort) frame_start = 1'b1;
        else         frame_done  = 1'b1;
        tick();
        idle(2);
    endtask

    initial begin
        int b0, b1, b2, br;
        int r;

        n_checks = 0; n_errors = 0; rdy_cnt = 0;
        for (int c = 0; c < 3; c++) w_cnt[c] = 0;
        model_reset();
        sysrst = 1'b1; config_done = 1'b0; frame_start = 1'b0; frame_done = 1'b0;
        pixel_valid = 1'b0; pixel_data = '0; mode = 2'd0; snap_req = 1'b0; skip_n = 4'd0;

        //                mode  skip  snap npix abort w0  w1  w2 rdy
        vecs[0]  = '{2'd0, 4'd0, 1'b0, 32, 1'b0, 32, 32, 8, 1};
        vecs[1]  = '{2'd0, 4'd0, 1'b0, 32, 1'b0, 32, 32, 8, 1};
        vecs[2]  = '{2'd0, 4'd0, 1'b0, 32, 1'b0, 32, 32, 8, 1};
        vecs[3]  = '{2'd2, 4'd2, 1'b0, 32, 1'b0, 32, 32, 8, 1};
        vecs[4]  = '{2'd2, 4'd2, 1'b0, 32, 1'b0,  0,  0, 0, 0};
        vecs[5]  = '{2'd2, 4'd2, 1'b0, 32, 1'b0,  0,  0, 0, 0};
        vecs[6]  = '{2'd2, 4'd2, 1'b0, 32, 1'b0, 32, 32, 8, 1};
        vecs[7]  = '{2'd2, 4'd2, 1'b0, 32, 1'b0,  0,  0, 0, 0};
        vecs[8]  = '{2'd2, 4'd2, 1'b0, 32, 1'b0,  0,  0, 0, 0};
        vecs[9]  = '{2'd1, 4'd0, 1'b1, 32, 1'b0, 32, 32, 8, 1};
        vecs[10] = '{2'd1, 4'd0, 1'b0, 32, 1'b0,  0,  0, 0, 0};
        vecs[11] = '{2'd1, 4'd0, 1'b0, 32, 1'b0,  0,  0, 0, 0};
        vecs[12] = '{2'd1, 4'd0, 1'b1, 32, 1'b0, 32, 32, 8, 1};
        vecs[13] = '{2'd0, 4'd0, 1'b1, 35, 1'b0, 32, 32, 8, 1};
        vecs[14] = '{2'd0, 4'd0, 1'b0, 10, 1'b1, 10, 10, 4, 0};
        vecs[15] = '{2'd0, 4'd0, 1'b0, 32, 1'b0, 32, 32, 8, 1};

        idle(2);
        reset_checks();
        sysrst = 1'b0;
        config_done = 1'b1;
        idle(1);

        for (int v = 0; v < NVEC; v++) begin
            b0 = w_cnt[0]; b1 = w_cnt[1]; b2 = w_cnt[2]; br = rdy_cnt;
            run_vec(vecs[v], 100 * v);
            check("vec writes d0", v, w_cnt[0] - b0, vecs[v].exp_w0);
            check("vec writes d1", v, w_cnt[1] - b1, vecs[v].exp_w1);
            check("vec writes d2", v, w_cnt[2] - b2, vecs[v].exp_w2);
            check("vec frame_ready", v, rdy_cnt - br, vecs[v].exp_ready);
        end
        check("table frame_count", 0, int'(fc0), 9);
        check("table overflow", 0, int'(ovf0), 1);
        check("table short_frame", 0, int'(sht0), 1);
        check("table read_bank", 1, int'(rb1), 0);

        // Reset in the middle of a frame.
        frame_start = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            pixel_valid = 1'b1; pixel_data = 12'(i); tick();
        end
        sysrst = 1'b1;
        tick();
        reset_checks();
        sysrst = 1'b0;
        idle(2);

        // Last pixel arrives together with frame_done.
        frame_start = 1'b1;
        tick();
        for (int i = 0; i < 31; i++) begin
            pixel_valid = 1'b1; pixel_data = 12'(500 + i); tick();
        end
        pixel_valid = 1'b1; pixel_data = 12'd777; frame_done = 1'b1;
        tick();
        check("simul wr_en", 0, int'(bus0.wr_en), 1);
        check("simul wr_addr", 0, int'(bus0.wr_addr), 31);
        check("simul wr_data", 0, int'(bus0.wr_data), 777);
        check("simul frame_ready", 0, int'(rdy0), 1);
        check("simul frame_count", 0, int'(fc0), 1);
        check("simul short_frame", 0, int'(sht0), 0);
        idle(2);

        // Stop request mid-frame: frame finishes, then captures cease.
        frame_start = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            if (i == 8) mode = 2'd3;
            pixel_valid = 1'b1; pixel_data = 12'(900 + i); tick();
        end
        frame_done = 1'b1;
        tick();
        check("stop commit frame_count", 0, int'(fc0), 2);
        idle(2);
        b0 = w_cnt[0];
        frame_start = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            pixel_valid = 1'b1; pixel_data = 12'(i); tick();
        end
        frame_done = 1'b1;
        tick();
        check("stop no writes", 0, w_cnt[0] - b0, 0);
        check("stop frame_count", 0, int'(fc0), 2);
        check("stop busy", 0, int'(busy0), 0);
        mode = 2'd0;
        idle(2);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            sysrst = ($urandom_range(0, 999) < 3);
            r = $urandom_range(0, 99);
            if (r < 2) begin
                frame_start = 1'b1;
            end else begin
                pixel_valid = ($urandom_range(0, 3) != 0);
                pixel_data  = 12'($urandom);
                if (r < 5) frame_done = 1'b1;
            end
            if ($urandom_range(0, 99) < 2) snap_req = 1'b1;
            if ($urandom_range(0, 199) == 0) begin
                mode   = 2'($urandom_range(0, 3));
                skip_n = 4'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 199) == 0) config_done = !config_done;
            tick();
        end
        sysrst = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/frame_capture_writer.md
Name: frame_capture_writer

Overview:
- Parametrised successor to the fixed 640x480 camera-to-BRAM write path.
- Takes the camera pixel stream (already in the system clock domain) and generates BRAM write enable, address and data.
- Adds decimation, single/double-buffer banking, snapshot and frame-skip modes, and frame-integrity error flags.
- Sits between `camera_read` plus `pixel_downsample` and `bram_memory`. `read_bank` tells `vga_interface` which bank to display.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- DATA_W, 12, pixel word width (RGB444)
- ADDR_W, 19, BRAM write address width; must hold NUM_BANKS*(H_RES>>DS_SHIFT)*(V_RES>>DS_SHIFT)-1
- DS_SHIFT, 0, decimation; keep every 2^DS_SHIFT-th pixel and line (legal values 0..2)
- NUM_BANKS, 1, 1 = single buffer, 2 = double buffer

Ports:
- sysclk  in  1  system clock; all logic on rising edge
- sysrst  in  1  synchronous active-high reset
- config_done  in  1  level; camera configuration complete
- frame_start  in  1  one-cycle strobe at start of frame (VSYNC)
- frame_done  in  1  one-cycle strobe at end of frame
- pixel_valid  in  1  one-cycle strobe; pixel_data valid
- pixel_data  in  DATA_W  pixel value
- mode  in  2  0 = continuous, 1 = snapshot, 2 = skip, 3 = stop
- snap_req  in  1  one-cycle strobe; arms one snapshot capture
- skip_n  in  4  frames ignored after each captured frame in skip mode
- wr_en  out  1  BRAM write enable
- wr_addr  out  ADDR_W  BRAM write address, bank offset included
- wr_data  out  DATA_W  BRAM write data
- read_bank  out  1  bank holding the last complete frame
- frame_ready  out  1  one-cycle pulse when a complete frame is committed
- busy  out  1  high in CAPTURE
- frame_count  out  16  complete frames committed, wraps at 65535->0
- overflow  out  1  sticky; frame had more than H_RES*V_RES valid pixels
- short_frame  out  1  sticky; frame ended with fewer than H_RES*V_RES valid pixels

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, write bank 0, skip counter 0, snapshot not armed.
  - Reset mid-capture abandons the frame with no writes, pulses or flag updates.
- States:
  - IDLE: wait for config_done=1 and mode!=3, then go to ARMED.
  - ARMED: on frame_start, decide whether to capture.
    - Capture when mode=0; or mode=1 with the snapshot armed; or mode=2 with skip counter 0.
    - Capturing: go to CAPTURE and clear x, y.
    - Not capturing in mode 2: decrement the skip counter.
  - CAPTURE: count pixels and write kept ones.
    - frame_done: commit (see below), then go to ARMED, or HOLD when mode=1.
  - HOLD: wait for snap_req, then go to ARMED.
  - mode=3 in any state: go to IDLE at the next frame boundary (frame_done or frame_start). An in-progress frame finishes normally.
- Snapshot: snap_req arms a capture in any state. It is cleared when the capture starts.
- Counting: each pixel_valid in CAPTURE advances x, 0..H_RES-1. When x wraps to 0, y increments.
- A pixel is kept when x[DS_SHIFT-1:0]==0 and y[DS_SHIFT-1:0]==0 (all pixels kept when DS_SHIFT=0).
- Address:
  - wr_addr = bank*BANK_SZ + (y>>DS)*(H_RES>>DS) + (x>>DS), where BANK_SZ = (H_RES>>DS)*(V_RES>>DS).
  - Generate it incrementally with a running row base; no multipliers.
- Latency: wr_en, wr_addr and wr_data are registered, one cycle after the qualifying pixel_valid. wr_en is high exactly one cycle per kept pixel.
- Overflow: once y reaches V_RES, further pixels are dropped (no write) and overflow is set.
- Commit on frame_done:
  - frame_count increments and frame_ready pulses one cycle later.
  - Committed with fewer pixels than H_RES*V_RES: short_frame is also set, and the frame still commits.
  - NUM_BANKS=2: read_bank takes the write bank and the write bank toggles.
  - NUM_BANKS=1: read_bank stays 0.
  - Mode 2: the skip counter loads skip_n.
- Simultaneous pixel_valid and frame_done: the pixel is counted and written first, then the frame is committed.
- frame_start while in CAPTURE: the current frame is aborted.
  - No commit, no bank swap, short_frame set.
  - The new frame starts at x=y=0 in the same bank.
- pixel_valid outside CAPTURE is ignored.
- frame_done outside CAPTURE is ignored.

Test Plan:
- Continuous, full frame.
  - Setup: H_RES=8, V_RES=4, DS_SHIFT=0, NUM_BANKS=1; config_done=1, mode=0, 32 pixels with values 0..31, then frame_done.
  - Required: wr_addr 0..31 with wr_data equal to addr, each one cycle after its pixel_valid; frame_ready pulse; frame_count=1; no flags set.
- Double buffer.
  - Setup: as above with NUM_BANKS=2; two full frames.
  - Required: frame 1 addresses 0..31, then read_bank=0; frame 2 addresses 32..63, then read_bank=1; third frame writes from 0 again.
- Decimation.
  - Setup: DS_SHIFT=1, H_RES=8, V_RES=4, 32 pixels.
  - Required: exactly 8 writes, at addr 0..7, from input pixel indices 0,2,4,6,16,18,20,22.
- Skip mode.
  - Setup: mode=2, skip_n=2, six frames.
  - Required: frames 1 and 4 captured, frames 2, 3, 5 and 6 produce no wr_en; frame_count=2.
- Snapshot.
  - Setup: mode=1; snap_req, then three frames.
  - Required: only the first frame is written; FSM stays in HOLD; a second snap_req captures the next frame.
- Error cases.
  - Stimulus: 35 pixels then frame_done.
    - Required: 32 writes and overflow=1.
  - Stimulus: 10 pixels then frame_start.
    - Required: short_frame=1, no frame_ready, next frame restarts at addr 0.
  - Stimulus: sysrst mid-frame.
    - Required: all outputs return to 0.
